// File: rtl/sram_rd_arbiter.sv
// Round-robin read arbiter sharing the single SRAM read port between two requesters.
// Optional `SRAM_RD_OUTREG_EN adds an output register on the SRAM read data (response in N+2).
module sram_rd_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              io_wbs_clk,
  input  logic              io_wbs_rst,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  output logic              req0_ready_o,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_data_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  output logic              req1_ready_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_data_o,
  output logic              mem_csb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_rr_ptr;
  logic [CNT_W-1:0]  r_burst_cnt;

  state_t            w_next_state;
  logic              w_next_rr;
  logic [CNT_W-1:0]  w_next_cnt;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_hs0;
  logic              w_hs1;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_pipe_busy;

  logic [DATA_W-1:0] r_rsp0_data;
  logic [DATA_W-1:0] r_rsp1_data;

  // Grant decision is made in the handshake cycle so a new owner is served with no bubble.
  always_comb begin
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_next_state = r_state;
    w_next_rr    = r_rr_ptr;
    w_next_cnt   = r_burst_cnt;
    unique case (r_state)
      IDLE: begin
        if (req0_valid_i && req1_valid_i) begin
          if (r_rr_ptr) begin
            w_grant1     = 1'b1;
            w_next_state = OWN1;
          end else begin
            w_grant0     = 1'b1;
            w_next_state = OWN0;
          end
          w_next_cnt = ONE_CNT;
        end else if (req0_valid_i) begin
          w_grant0     = 1'b1;
          w_next_state = OWN0;
          w_next_cnt   = ONE_CNT;
        end else if (req1_valid_i) begin
          w_grant1     = 1'b1;
          w_next_state = OWN1;
          w_next_cnt   = ONE_CNT;
        end
      end
      OWN0: begin
        if (req0_valid_i && (!req1_valid_i || (r_burst_cnt < MAX_CNT))) begin
          w_grant0   = 1'b1;
          w_next_cnt = (r_burst_cnt == MAX_CNT) ? r_burst_cnt : r_burst_cnt + ONE_CNT;
        end else if (req1_valid_i) begin
          w_grant1     = 1'b1;
          w_next_state = OWN1;
          w_next_cnt   = ONE_CNT;
          if (req0_valid_i) begin
            w_next_rr = 1'b0;
          end
        end else begin
          w_next_state = IDLE;
          w_next_rr    = 1'b1;
          w_next_cnt   = '0;
        end
      end
      OWN1: begin
        if (req1_valid_i && (!req0_valid_i || (r_burst_cnt < MAX_CNT))) begin
          w_grant1   = 1'b1;
          w_next_cnt = (r_burst_cnt == MAX_CNT) ? r_burst_cnt : r_burst_cnt + ONE_CNT;
        end else if (req0_valid_i) begin
          w_grant0     = 1'b1;
          w_next_state = OWN0;
          w_next_cnt   = ONE_CNT;
          if (req1_valid_i) begin
            w_next_rr = 1'b1;
          end
        end else begin
          w_next_state = IDLE;
          w_next_rr    = 1'b0;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // While reset is held no request may be accepted, even though the FSM already sits in IDLE.
  assign w_hs0 = w_grant0 & ~io_wbs_rst;
  assign w_hs1 = w_grant1 & ~io_wbs_rst;

  assign req0_ready_o = w_hs0;
  assign req1_ready_o = w_hs1;
  assign mem_csb_o    = ~(w_hs0 | w_hs1);
  assign mem_addr_o   = w_hs0 ? req0_addr_i : (w_hs1 ? req1_addr_i : '0);

  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_rr_ptr    <= w_next_rr;
      r_burst_cnt <= w_next_cnt;
    end
  end

`ifdef SRAM_RD_OUTREG_EN
  logic r_tag1_vld;
  logic r_tag1_id;
  logic r_tag2_vld;
  logic r_tag2_id;

  // Two-stage tag pipe: stage 1 marks the cycle SRAM data appears, stage 2 the response cycle.
  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      r_tag1_vld <= 1'b0;
      r_tag1_id  <= 1'b0;
      r_tag2_vld <= 1'b0;
      r_tag2_id  <= 1'b0;
    end else begin
      r_tag1_vld <= w_hs0 | w_hs1;
      r_tag1_id  <= w_hs1;
      r_tag2_vld <= r_tag1_vld;
      r_tag2_id  <= r_tag1_id;
    end
  end

  assign w_hit0      = r_tag1_vld & ~r_tag1_id;
  assign w_hit1      = r_tag1_vld &  r_tag1_id;
  assign w_pipe_busy = r_tag1_vld | r_tag2_vld;

  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      r_rsp0_data <= '0;
      r_rsp1_data <= '0;
    end else begin
      if (w_hit0) begin
        r_rsp0_data <= mem_dout_i;
      end
      if (w_hit1) begin
        r_rsp1_data <= mem_dout_i;
      end
    end
  end

  assign rsp0_valid_o = r_tag2_vld & ~r_tag2_id;
  assign rsp1_valid_o = r_tag2_vld &  r_tag2_id;
  assign rsp0_data_o  = r_rsp0_data;
  assign rsp1_data_o  = r_rsp1_data;
`else
  logic r_tag_vld;
  logic r_tag_id;

  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      r_tag_vld <= 1'b0;
      r_tag_id  <= 1'b0;
    end else begin
      r_tag_vld <= w_hs0 | w_hs1;
      r_tag_id  <= w_hs1;
    end
  end

  assign w_hit0      = r_tag_vld & ~r_tag_id;
  assign w_hit1      = r_tag_vld &  r_tag_id;
  assign w_pipe_busy = r_tag_vld;

  // Shadow copies keep the last delivered word visible when the other requester is served.
  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      r_rsp0_data <= '0;
      r_rsp1_data <= '0;
    end else begin
      if (w_hit0) begin
        r_rsp0_data <= mem_dout_i;
      end
      if (w_hit1) begin
        r_rsp1_data <= mem_dout_i;
      end
    end
  end

  assign rsp0_valid_o = w_hit0;
  assign rsp1_valid_o = w_hit1;
  assign rsp0_data_o  = w_hit0 ? mem_dout_i : r_rsp0_data;
  assign rsp1_data_o  = w_hit1 ? mem_dout_i : r_rsp1_data;
`endif

  assign busy_o = (r_state != IDLE) | w_pipe_busy;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Self-checking bench for sram_rd_arbiter: abstract arbitration/response model plus directed scenarios.
module tb_sram_rd_arbiter;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
`ifdef SRAM_RD_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              v0 = 1'b0;
  logic              v1 = 1'b0;
  logic [ADDR_W-1:0] a0 = '0;
  logic [ADDR_W-1:0] a1 = '0;
  logic              ready0;
  logic              ready1;
  logic              rsp0Valid;
  logic              rsp1Valid;
  logic [DATA_W-1:0] rsp0Data;
  logic [DATA_W-1:0] rsp1Data;
  logic              memCsb;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDout = '0;
  logic              busy;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  sram_rd_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .io_wbs_clk(clk),
    .io_wbs_rst(rst),
    .req0_valid_i(v0),
    .req0_addr_i(a0),
    .req0_ready_o(ready0),
    .rsp0_valid_o(rsp0Valid),
    .rsp0_data_o(rsp0Data),
    .req1_valid_i(v1),
    .req1_addr_i(a1),
    .req1_ready_o(ready1),
    .rsp1_valid_o(rsp1Valid),
    .rsp1_data_o(rsp1Data),
    .mem_csb_o(memCsb),
    .mem_addr_o(memAddr),
    .mem_dout_i(memDout),
    .busy_o(busy)
  );

  // SRAM read port: data appears the cycle after csb is sampled low and holds otherwise.
  always @(posedge clk) begin
    if (!memCsb) begin
      memDout <= mem[memAddr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic nv0, input logic [ADDR_W-1:0] na0,
                               input logic nv1, input logic [ADDR_W-1:0] na1);
    @(posedge clk);
    #1;
    v0 = nv0;
    a0 = na0;
    v1 = nv1;
    a1 = na1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    v0  = 1'b0;
    v1  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Model: who owns the port, how long the current streak is, and who wins the next tie.
  typedef struct {
    int                due;
    int                id;
    logic [DATA_W-1:0] data;
  } rsp_t;

  int                mOwner  = -1;
  int                mStreak = 0;
  int                mPref   = 0;
  int                mCycle  = 0;
  rsp_t              mPend[$];
  logic [DATA_W-1:0] mLast0  = '0;
  logic [DATA_W-1:0] mLast1  = '0;

  function automatic logic wants(input int who);
    return (who == 0) ? v0 : v1;
  endfunction

  function automatic int pickGrant();
    int other;
    if (mOwner < 0) begin
      if (v0 && v1) return mPref;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
    end
    other = 1 - mOwner;
    if (wants(mOwner) && (!wants(other) || mStreak < MAX_BURST)) return mOwner;
    if (wants(other)) return other;
    return -1;
  endfunction

  always @(negedge clk) begin : compareProc
    int                g;
    logic [ADDR_W-1:0] eAddr;
    logic              eBusy;
    logic              e0v;
    logic              e1v;
    logic [DATA_W-1:0] e0d;
    logic [DATA_W-1:0] e1d;
    mCycle++;
    if (rst) begin
      mOwner  = -1;
      mStreak = 0;
      mPref   = 0;
      mPend.delete();
      mLast0  = '0;
      mLast1  = '0;
      g       = -1;
    end else begin
      g = pickGrant();
    end
    eAddr = (g == 0) ? a0 : ((g == 1) ? a1 : '0);
    eBusy = (mOwner >= 0) || (mPend.size() > 0);
    e0v = 1'b0;
    e1v = 1'b0;
    if (mPend.size() > 0 && mPend[0].due == mCycle) begin
      if (mPend[0].id == 0) begin
        e0v   = 1'b1;
        mLast0 = mPend[0].data;
      end else begin
        e1v   = 1'b1;
        mLast1 = mPend[0].data;
      end
      void'(mPend.pop_front());
    end
    e0d = mLast0;
    e1d = mLast1;
    checkOutput("model_ready0", 32'(ready0), 32'(g == 0));
    checkOutput("model_ready1", 32'(ready1), 32'(g == 1));
    checkOutput("model_csb", 32'(memCsb), 32'(g < 0));
    checkOutput("model_addr", 32'(memAddr), 32'(eAddr));
    checkOutput("model_busy", 32'(busy), 32'(eBusy));
    checkOutput("model_rsp0_valid", 32'(rsp0Valid), 32'(e0v));
    checkOutput("model_rsp0_data", rsp0Data, e0d);
    checkOutput("model_rsp1_valid", 32'(rsp1Valid), 32'(e1v));
    checkOutput("model_rsp1_data", rsp1Data, e1d);
    if (!rst) begin
      if (g >= 0) begin
        mPend.push_back('{due: mCycle + LAT, id: g, data: mem[eAddr]});
      end
      if (g < 0) begin
        if (mOwner >= 0) mPref = 1 - mOwner;
        mOwner  = -1;
        mStreak = 0;
      end else if (g == mOwner) begin
        if (mStreak < MAX_BURST) mStreak++;
      end else begin
        if (mOwner >= 0 && wants(mOwner)) mPref = mOwner;
        mOwner  = g;
        mStreak = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int t3Exp[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int t4Exp[7]  = '{1, 1, 0, 0, 0, 0, 1};
    logic t4V0[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic t4V1[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int   got;
    int   waitCycles;
    logic gotReady;

    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = 32'hC0DE0000 | 32'(i);
    end
    mem[5] = 32'hDEADBEEF;

    // Reset held with both requesters asking: nothing may be accepted.
    rst = 1'b1;
    v0 = 1'b1;
    v1 = 1'b1;
    a0 = 10'h003;
    a1 = 10'h004;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t1_ready0", 32'(ready0), 32'd0);
      checkOutput("t1_ready1", 32'(ready1), 32'd0);
      checkOutput("t1_csb", 32'(memCsb), 32'd1);
      checkOutput("t1_busy", 32'(busy), 32'd0);
      checkOutput("t1_rsp0_valid", 32'(rsp0Valid), 32'd0);
      checkOutput("t1_rsp0_data", rsp0Data, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    @(negedge clk);

    // Single read from requester 0.
    applyStimulus(1'b1, 10'h005, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("t2_ready0", 32'(ready0), 32'd1);
    checkOutput("t2_csb", 32'(memCsb), 32'd0);
    checkOutput("t2_addr", 32'(memAddr), 32'h005);
    repeat (LAT - 1) begin
      applyStimulus(1'b0, 10'h000, 1'b0, 10'h000);
      @(negedge clk);
    end
    applyStimulus(1'b0, 10'h000, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("t2_rsp0_valid", 32'(rsp0Valid), 32'd1);
    checkOutput("t2_rsp0_data", rsp0Data, 32'hDEADBEEF);
    checkOutput("t2_rsp1_valid", 32'(rsp1Valid), 32'd0);

    // Contention from a fresh reset.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 10'(i), 1'b1, 10'(10'h200 + i));
      @(negedge clk);
      got = ready1 ? 1 : (ready0 ? 0 : 2);
      checkOutput("t3_grant", 32'(got), 32'(t3Exp[i]));
      checkOutput("t3_csb", 32'(memCsb), 32'd0);
    end
    repeat (LAT + 1) begin
      applyStimulus(1'b0, 10'h000, 1'b0, 10'h000);
      @(negedge clk);
    end

    // Requester 1 bursts two beats then drops while requester 0 waits.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(t4V0[i], 10'(10'h040 + i), t4V1[i], 10'(10'h080 + i));
      @(negedge clk);
      got = ready1 ? 1 : (ready0 ? 0 : 2);
      checkOutput("t4_grant", 32'(got), 32'(t4Exp[i]));
    end
    repeat (LAT + 1) begin
      applyStimulus(1'b0, 10'h000, 1'b0, 10'h000);
      @(negedge clk);
    end

    // Leave the tie-break pointing at requester 1, then reset during a read.
    applyStimulus(1'b1, 10'h011, 1'b0, 10'h000);
    @(negedge clk);
    applyStimulus(1'b0, 10'h000, 1'b0, 10'h000);
    @(negedge clk);
    applyStimulus(1'b0, 10'h000, 1'b1, 10'h010);
    @(negedge clk);
    checkOutput("t5_ready1", 32'(ready1), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    v1  = 1'b0;
    @(negedge clk);
    checkOutput("t5_rsp1_valid_n1", 32'(rsp1Valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("t5_rsp1_valid_n2", 32'(rsp1Valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v0 = 1'b1;
    a0 = 10'h012;
    v1 = 1'b1;
    a1 = 10'h013;
    @(negedge clk);
    checkOutput("t5_after_ready0", 32'(ready0), 32'd1);
    checkOutput("t5_after_ready1", 32'(ready1), 32'd0);

    // Requester 0 streams; requester 1 arrives mid-burst and must be served within the burst limit.
    applyStimulus(1'b1, 10'h020, 1'b0, 10'h000);
    @(negedge clk);
    waitCycles = 0;
    gotReady   = 1'b0;
    while (!gotReady && waitCycles < 8) begin
      applyStimulus(1'b1, 10'(10'h021 + waitCycles), 1'b1,
                    (waitCycles == 0) ? 10'h100 : 10'h3FF);
      waitCycles++;
      @(negedge clk);
      gotReady = ready1;
    end
    checkOutput("t6_wait_cycles", 32'(waitCycles), 32'd3);
    checkOutput("t6_addr", 32'(memAddr), 32'h3FF);
    for (int k = 0; k < LAT; k++) begin
      applyStimulus(1'b1, 10'h030, 1'b0, 10'h000);
      @(negedge clk);
    end
    checkOutput("t6_rsp1_valid", 32'(rsp1Valid), 32'd1);
    checkOutput("t6_rsp1_data", rsp1Data, 32'hC0DE03FF);

    repeat (LAT + 2) begin
      applyStimulus(1'b0, 10'h000, 1'b0, 10'h000);
      @(negedge clk);
    end
    checkOutput("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
